dmem_scan_checker: RTL and testbench

//  Self-check engine downstream of the CPU data memory.

---
 rtl/dmem_scan_checker.sv | 97 +++++++++
 tb/tb_dmem_scan_checker.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_scan_checker.sv
// Post-run self-check: waits RUN_CYCLES after reset, then takes over the dmem read port,
// compares NWORDS words against an expected-value ROM and reports mismatches.
module dmem_scan_checker #(
    parameter int RUN_CYCLES = 1000,
    parameter int NWORDS     = 32,
    parameter int CW         = 6
) (
    input  logic          clk,
    input  logic          reset,
    output logic          chk_active,
    output logic [31:0]   chk_daddr,
    input  logic [31:0]   chk_drdata,
    output logic [4:0]    exp_addr,
    input  logic [31:0]   exp_data,
    output logic          err_valid,
    output logic [4:0]    err_index,
    output logic [31:0]   err_got,
    output logic [31:0]   err_exp,
    output logic [CW-1:0] mismatch_cnt,
    output logic          done,
    output logic          pass
);

    localparam int             RCW      = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
    localparam logic [RCW-1:0] RUN_LAST = RCW'(RUN_CYCLES - 1);
    localparam logic [4:0]     IDX_LAST = 5'(NWORDS - 1);

    typedef enum logic [1:0] {
        RUN,
        SCAN,
        DONE
    } state_t;

    state_t         state;
    logic [RCW-1:0] cycle_cnt;
    logic [4:0]     scan_idx;
    logic           mismatch;

    assign mismatch  = (chk_drdata != exp_data);
    assign chk_daddr = {25'b0, scan_idx, 2'b00};
    assign exp_addr  = scan_idx;

    // chk_active, done and pass are flops so no input ever reaches an output combinationally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= RUN;
            cycle_cnt    <= '0;
            scan_idx     <= '0;
            chk_active   <= 1'b0;
            err_valid    <= 1'b0;
            err_index    <= '0;
            err_got      <= '0;
            err_exp      <= '0;
            mismatch_cnt <= '0;
            done         <= 1'b0;
            pass         <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    cycle_cnt <= cycle_cnt + 1'b1;
                    if (cycle_cnt == RUN_LAST) begin
                        state      <= SCAN;
                        scan_idx   <= '0;
                        chk_active <= 1'b1;
                    end
                end
                SCAN: begin
                    err_valid <= mismatch;
                    if (mismatch) begin
                        err_index <= scan_idx;
                        err_got   <= chk_drdata;
                        err_exp   <= exp_data;
                        if (mismatch_cnt != '1) begin
                            mismatch_cnt <= mismatch_cnt + 1'b1;
                        end
                    end
                    // The last word's compare result is folded into pass here, not a cycle later.
                    if (scan_idx == IDX_LAST) begin
                        state      <= DONE;
                        chk_active <= 1'b0;
                        done       <= 1'b1;
                        pass       <= (mismatch_cnt == '0) && !mismatch;
                    end else begin
                        scan_idx <= scan_idx + 1'b1;
                    end
                end
                DONE: begin
                    err_valid <= 1'b0;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_scan_checker.sv
// Scoreboard bench for dmem_scan_checker: expected error records are queued when memories are
// loaded and popped on each err_valid pulse; also covers a tiny and a saturating configuration.
module tb_dmem_scan_checker;

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] got;
        logic [31:0] exp;
    } errRec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic resetSmall;

    logic        chk_active;
    logic [31:0] chk_daddr;
    logic [31:0] chk_drdata;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    logic        err_valid;
    logic [4:0]  err_index;
    logic [31:0] err_got;
    logic [31:0] err_exp;
    logic [5:0]  mismatch_cnt;
    logic        done;
    logic        pass;

    logic [31:0] dmem [32];
    logic [31:0] rom  [32];

    assign chk_drdata = dmem[chk_daddr[6:2]];
    assign exp_data   = rom[exp_addr];

    dmem_scan_checker #(.RUN_CYCLES(1000), .NWORDS(32), .CW(6)) dut (
        .clk(clk), .reset(reset),
        .chk_active(chk_active), .chk_daddr(chk_daddr), .chk_drdata(chk_drdata),
        .exp_addr(exp_addr), .exp_data(exp_data),
        .err_valid(err_valid), .err_index(err_index), .err_got(err_got), .err_exp(err_exp),
        .mismatch_cnt(mismatch_cnt), .done(done), .pass(pass)
    );

    logic        activeSmall;
    logic [31:0] daddrSmall;
    logic [31:0] drdataSmall;
    logic [4:0]  expAddrSmall;
    logic [31:0] expDataSmall;
    logic        errValidSmall;
    logic [4:0]  errIndexSmall;
    logic [31:0] errGotSmall;
    logic [31:0] errExpSmall;
    logic [1:0]  cntSmall;
    logic        doneSmall;
    logic        passSmall;

    logic [31:0] dmemSmall [2];
    logic [31:0] romSmall  [2];

    assign drdataSmall  = dmemSmall[daddrSmall[2]];
    assign expDataSmall = romSmall[expAddrSmall[0]];

    dmem_scan_checker #(.RUN_CYCLES(4), .NWORDS(2), .CW(2)) dutSmall (
        .clk(clk), .reset(resetSmall),
        .chk_active(activeSmall), .chk_daddr(daddrSmall), .chk_drdata(drdataSmall),
        .exp_addr(expAddrSmall), .exp_data(expDataSmall),
        .err_valid(errValidSmall), .err_index(errIndexSmall), .err_got(errGotSmall), .err_exp(errExpSmall),
        .mismatch_cnt(cntSmall), .done(doneSmall), .pass(passSmall)
    );

    logic        activeSat;
    logic [31:0] daddrSat;
    logic [31:0] drdataSat;
    logic [4:0]  expAddrSat;
    logic [31:0] expDataSat;
    logic        errValidSat;
    logic [4:0]  errIndexSat;
    logic [31:0] errGotSat;
    logic [31:0] errExpSat;
    logic [1:0]  cntSat;
    logic        doneSat;
    logic        passSat;

    assign drdataSat  = {27'b0, daddrSat[6:2]};
    assign expDataSat = 32'hFFFF_0000;

    dmem_scan_checker #(.RUN_CYCLES(2), .NWORDS(5), .CW(2)) dutSat (
        .clk(clk), .reset(resetSmall),
        .chk_active(activeSat), .chk_daddr(daddrSat), .chk_drdata(drdataSat),
        .exp_addr(expAddrSat), .exp_data(expDataSat),
        .err_valid(errValidSat), .err_index(errIndexSat), .err_got(errGotSat), .err_exp(errExpSat),
        .mismatch_cnt(cntSat), .done(doneSat), .pass(passSat)
    );

    int      tests = 0;
    int      fails = 0;
    errRec_t sb [$];
    errRec_t lastRec;
    int      expCnt;
    logic    found;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Loads dmem/ROM for one scenario and queues the error records the scan must report.
    task automatic applyStimulus(input int pattern);
        errRec_t rec;
        logic [31:0] word;
        sb.delete();
        expCnt  = 0;
        lastRec = '0;
        for (int i = 0; i < 32; i++) begin
            word    = $urandom;
            dmem[i] = word;
            rom[i]  = word;
        end
        case (pattern)
            2: begin
                dmem[5] = 32'hDEAD_BEEF;
                rom[5]  = 32'h1234_5678;
            end
            3: for (int i = 0; i < 32; i++) rom[i] = ~dmem[i];
            4: rom[31] = dmem[31] ^ 32'h0000_0100;
            default: ;
        endcase
        for (int i = 0; i < 32; i++) begin
            if (dmem[i] !== rom[i]) begin
                rec.idx = 5'(i);
                rec.got = dmem[i];
                rec.exp = rom[i];
                sb.push_back(rec);
                lastRec = rec;
                if (expCnt < 63) expCnt++;
            end
        end
    endtask

    // Entered with reset asserted; releases it and follows the main DUT to done.
    task automatic runScan(input string name);
        errRec_t rec;
        int doneEdge = 0;
        int active   = 0;
        int addrBad  = 0;
        @(negedge clk);
        reset = 1'b1;
        for (int e = 1; e <= 1100 && doneEdge == 0; e++) begin
            if (err_valid) begin
                if (sb.size() > 0) begin
                    rec = sb.pop_front();
                    checkOutput({name, "_err_index"}, 32'(err_index), 32'(rec.idx));
                    checkOutput({name, "_err_got"}, err_got, rec.got);
                    checkOutput({name, "_err_exp"}, err_exp, rec.exp);
                end else begin
                    checkOutput({name, "_err_spurious"}, 32'(err_valid), 32'd0);
                end
            end
            if (chk_active) begin
                if (exp_addr != 5'(active) || chk_daddr != 32'(active * 4)) addrBad++;
                active++;
            end
            if (done) doneEdge = e;
            else @(negedge clk);
        end
        checkOutput({name, "_done_edge"}, 32'(doneEdge), 32'd1033);
        checkOutput({name, "_active_cycles"}, 32'(active), 32'd32);
        checkOutput({name, "_addr_seq"}, 32'(addrBad), 32'd0);
        checkOutput({name, "_cnt"}, 32'(mismatch_cnt), 32'(expCnt));
        checkOutput({name, "_pass"}, 32'(pass), 32'(expCnt == 0));
        checkOutput({name, "_last_index"}, 32'(err_index), 32'(lastRec.idx));
        checkOutput({name, "_last_got"}, err_got, lastRec.got);
        checkOutput({name, "_last_exp"}, err_exp, lastRec.exp);
        checkOutput({name, "_sb_leftover"}, 32'(sb.size()), 32'd0);
        @(negedge clk);
        checkOutput({name, "_err_valid_after"}, 32'(err_valid), 32'd0);
        checkOutput({name, "_done_sticky"}, 32'(done), 32'd1);
    endtask

    initial begin
        logic [31:0] activeMask;
        int doneEdgeSmall;
        int doneEdgeSat;
        int pulsesSmall;

        reset      = 1'b0;
        resetSmall = 1'b0;
        dmemSmall[0] = 32'hA5A5_0000; romSmall[0] = 32'hA5A5_0000;
        dmemSmall[1] = 32'h0000_1111; romSmall[1] = 32'h0000_2222;
        applyStimulus(1);
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_outputs_zero", 32'(|{chk_active, chk_daddr, exp_addr, err_valid, err_index,
                    err_got, err_exp, mismatch_cnt, done, pass}), 32'd0);

        runScan("match_all");
        reset = 1'b0;
        applyStimulus(2);
        runScan("word5");
        reset = 1'b0;
        applyStimulus(3);
        runScan("all_differ");
        reset = 1'b0;
        applyStimulus(4);
        runScan("last_word");

        reset = 1'b0;
        applyStimulus(2);
        @(negedge clk);
        reset = 1'b1;
        found = 1'b0;
        for (int e = 1; e <= 1100 && !found; e++) begin
            if (chk_active && exp_addr == 5'd10) found = 1'b1;
            else @(negedge clk);
        end
        checkOutput("abort_reached_idx10", 32'(found), 32'd1);
        checkOutput("abort_cnt_before", 32'(mismatch_cnt), 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("abort_outputs_zero", 32'(|{chk_active, chk_daddr, exp_addr, err_valid, err_index,
                    err_got, err_exp, mismatch_cnt, done, pass}), 32'd0);
        applyStimulus(4);
        runScan("restart");

        checkOutput("small_reset_zero", 32'(|{activeSmall, daddrSmall, doneSmall, passSmall, cntSmall,
                    errValidSmall, activeSat, doneSat, cntSat}), 32'd0);
        activeMask    = '0;
        doneEdgeSmall = 0;
        doneEdgeSat   = 0;
        pulsesSmall   = 0;
        resetSmall    = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            activeMask[e] = activeSmall;
            if (errValidSmall) pulsesSmall++;
            if (doneSmall && doneEdgeSmall == 0) doneEdgeSmall = e;
            if (doneSat && doneEdgeSat == 0) doneEdgeSat = e;
            @(negedge clk);
        end
        checkOutput("small_active_edges", activeMask, 32'h0000_0060);
        checkOutput("small_done_edge", 32'(doneEdgeSmall), 32'd7);
        checkOutput("small_err_pulses", 32'(pulsesSmall), 32'd1);
        checkOutput("small_err_index", 32'(errIndexSmall), 32'd1);
        checkOutput("small_err_got", errGotSmall, 32'h0000_1111);
        checkOutput("small_err_exp", errExpSmall, 32'h0000_2222);
        checkOutput("small_cnt", 32'(cntSmall), 32'd1);
        checkOutput("small_pass", 32'(passSmall), 32'd0);
        checkOutput("sat_done_edge", 32'(doneEdgeSat), 32'd8);
        checkOutput("sat_cnt", 32'(cntSat), 32'd3);
        checkOutput("sat_pass", 32'(passSat), 32'd0);
        checkOutput("sat_last_index", 32'(errIndexSat), 32'd4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
